// File: rtl/cache_refill_responder.sv
// Backing-store responder for the data cache: serves line refills as a beat burst and
// dirty-line writebacks with a single ack, both after a fixed request-to-response latency.
module cache_refill_responder #(
  parameter int unsigned LINE_WORDS     = 4,
  parameter int unsigned LATENCY        = 3,
  parameter int unsigned MEM_ADDR_WIDTH = 17,
  parameter string       INIT_FILE      = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [32*LINE_WORDS-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_last,
  output logic [31:0]              rsp_rdata
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS * 4);
  localparam int unsigned BeatW = $clog2(LINE_WORDS);
  localparam int unsigned LineW = MEM_ADDR_WIDTH - OffW;
  localparam int unsigned Depth = 2 ** (MEM_ADDR_WIDTH - 2);
  localparam int unsigned CntW  = $clog2(LATENCY + 1);

  // WAIT lasts LATENCY-1 cycles; the final WAIT edge loads the first beat registers.
  localparam logic [CntW-1:0]  CntInit  = (LATENCY >= 2) ? CntW'(LATENCY - 2) : '0;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StWack} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BeatW-1:0]  beat_q;
  logic [LineW-1:0]  line_q;
  logic              write_q;

  logic [31:0]       mem [Depth];

  logic [LineW-1:0]  req_line;
  logic [BeatW-1:0]  beat_nxt;
  logic              start;
  logic [LineW-1:0]  start_line;
  logic              start_write;
  logic              unused_addr;

  assign req_line    = req_addr[MEM_ADDR_WIDTH-1:OffW];
  assign unused_addr = ^{req_addr[31:MEM_ADDR_WIDTH], req_addr[OffW-1:0]};
  assign req_ready   = (state_q == StIdle);
  assign beat_nxt    = beat_q + BeatW'(1);

  // Writebacks commit the whole line at the handshake edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && req_valid && req_ready && req_write) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        mem[{req_line, BeatW'(i)}] <= req_wdata[32*i +: 32];
      end
    end
  end

  // start: this edge loads the first response beat (end of cycle c+LATENCY-1).
  always_comb begin
    start       = 1'b0;
    start_line  = line_q;
    start_write = write_q;
    if (state_q == StIdle) begin
      start       = req_valid && (LATENCY == 1);
      start_line  = req_line;
      start_write = req_write;
    end else if (state_q == StWait) begin
      start = (cnt_q == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      beat_q    <= '0;
      line_q    <= '0;
      write_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            line_q  <= req_line;
            write_q <= req_write;
            cnt_q   <= CntInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
        end
        StBurst: begin
          if (beat_q == LastBeat) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            beat_q    <= beat_nxt;
            rsp_rdata <= mem[{line_q, beat_nxt}];
            rsp_last  <= (beat_nxt == LastBeat);
          end
        end
        StWack: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
          rsp_last  <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state_q <= StIdle;
      endcase

      if (start) begin
        beat_q    <= '0;
        rsp_valid <= 1'b1;
        if (start_write) begin
          state_q   <= StWack;
          rsp_last  <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          state_q   <= StBurst;
          rsp_last  <= 1'b0;
          rsp_rdata <= mem[{start_line, BeatW'(0)}];
        end
      end
    end
  end

endmodule
